// File: rtl/spike_aer_encoder.sv
// Round-robin AER encoder: pends per-neuron spikes, grants one per cycle into an event FIFO.
// Optional per-event timestamps are enabled with `define AER_TIMESTAMP_EN.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_NEURONS-1:0]          spike_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ADDR_W-1:0]             ev_addr,
  output logic [TS_WIDTH-1:0]           ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int NCNT_W = $clog2(N_NEURONS + 1);
  localparam int SUM_W  = DROP_W + NCNT_W;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] gnt_vec;
  logic [N_NEURONS-1:0] drop_vec;
  logic [ADDR_W-1:0]    rr_ptr;
  logic [ADDR_W-1:0]    grant;
  logic                 found;
  logic                 grant_valid;
  int                   idx;
  logic [NCNT_W-1:0]    n_drops;
  logic [SUM_W-1:0]     drop_sum;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];
  logic                 fifo_full;
  logic                 pop;

  assign ev_valid  = (fifo_level != '0);
  assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = ev_valid && ev_ready;
  assign ev_addr   = addr_mem[rd_ptr];

  // Search starts at rr_ptr and wraps; fullness uses the start-of-cycle level only.
  always_comb begin
    grant       = '0;
    gnt_vec     = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_NEURONS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_NEURONS) idx = idx - N_NEURONS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = ADDR_W'(idx);
      end
    end
    grant_valid = found && !fifo_full;
    if (grant_valid) gnt_vec[grant] = 1'b1;
  end

  // A re-spike on a still-pending, ungranted neuron is lost.
  always_comb begin
    drop_vec = spike_in & pending & ~gnt_vec;
    n_drops  = '0;
    for (int i = 0; i < N_NEURONS; i++) n_drops = n_drops + NCNT_W'(drop_vec[i]);
    drop_sum = SUM_W'(drop_count) + SUM_W'(n_drops);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      pending <= (pending & ~gnt_vec) | spike_in;
      if (grant_valid) begin
        rr_ptr <= (int'(grant) == N_NEURONS - 1) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LVL_W'(grant_valid) - LVL_W'(pop);
      drop_count <= (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid) addr_mem[wr_ptr] <= grant;
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  ts;
  logic [TS_WIDTH-1:0]  pend_ts [N_NEURONS];
  logic [TS_WIDTH-1:0]  ts_mem  [FIFO_DEPTH];
  logic [N_NEURONS-1:0] latch_vec;

  // New pend or re-pend of the neuron being granted both take the current ts.
  assign latch_vec = spike_in & ~(pending & ~gnt_vec);
  assign ev_ts     = ts_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts <= '0;
      for (int i = 0; i < N_NEURONS; i++) pend_ts[i] <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (latch_vec[i]) pend_ts[i] <= ts;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid) ts_mem[wr_ptr] <= pend_ts[grant];
  end
`else
  assign ev_ts = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed vector table plus multi-cycle sequences.
module tb_spike_aer_encoder;

`ifdef AER_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  spike_in = '0;
  logic        ev_ready = 1'b1;
  logic        ev_valid;
  logic [2:0]  ev_addr;
  logic [15:0] ev_ts;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;

  logic        s_rst_n = 1'b0;
  logic [7:0]  s_spike = '0;
  logic        s_ready = 1'b1;
  logic        s_valid;
  logic [2:0]  s_addr;
  logic [3:0]  s_ts;
  logic [3:0]  s_level;
  logic [3:0]  s_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_addr(ev_addr), .ev_ts(ev_ts), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  spike_aer_encoder #(.TS_WIDTH(4), .DROP_W(4)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .spike_in(s_spike), .ev_valid(s_valid), .ev_ready(s_ready),
    .ev_addr(s_addr), .ev_ts(s_ts), .fifo_level(s_level), .drop_count(s_drop)
  );

  typedef struct {
    logic        rst_n;
    logic [7:0]  spike;
    logic        ready;
    int          n;
    logic        exp_valid;
    logic [2:0]  exp_addr;
    logic [15:0] exp_ts;
    logic [3:0]  exp_level;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] exp_ts(input int t);
    return TS_ON ? 32'(t) : 32'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [7:0] sp, input logic rdy, input int n);
    rst_n    = r;
    spike_in = sp;
    ev_ready = rdy;
    tick(n);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 8'h00, ev_ready, 1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;

    // Reset, single spike at ts=10, then a burst and an rr_ptr probe after a fresh reset.
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[1]  = '{1'b1, 8'h00, 1'b1, 10, 1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[2]  = '{1'b1, 8'h08, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd3, 16'd10, 4'd1, 8'd0};
    vecs[4]  = '{1'b1, 8'h00, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[6]  = '{1'b1, 8'h00, 1'b1, 2,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[7]  = '{1'b1, 8'hA1, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd0, 16'd2,  4'd1, 8'd0};
    vecs[9]  = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd5, 16'd2,  4'd1, 8'd0};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd7, 16'd2,  4'd1, 8'd0};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[12] = '{1'b1, 8'h81, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};
    vecs[13] = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd0, 16'd7,  4'd1, 8'd0};
    vecs[14] = '{1'b1, 8'h00, 1'b1, 1,  1'b1, 3'd7, 16'd7,  4'd1, 8'd0};
    vecs[15] = '{1'b1, 8'h00, 1'b1, 1,  1'b0, 3'd0, 16'd0,  4'd0, 8'd0};

    #1;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].spike, vecs[i].ready, vecs[i].n);
      check_output($sformatf("row%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("row%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      check_output($sformatf("row%0d_drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      if (vecs[i].exp_valid) begin
        check_output($sformatf("row%0d_addr", i), 32'(ev_addr), 32'(vecs[i].exp_addr));
        check_output($sformatf("row%0d_ts", i), 32'(ev_ts), exp_ts(int'(vecs[i].exp_ts)));
      end
    end

    // Fairness: neurons 1 and 2 held high alternate grants, one drop per cycle.
    ev_ready = 1'b1;
    do_reset();
    apply_stimulus(1'b1, 8'h06, 1'b1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check_output($sformatf("fair%0d_valid", k), 32'(ev_valid), 32'd1);
      check_output($sformatf("fair%0d_addr", k), 32'(ev_addr), (k % 2 == 1) ? 32'd1 : 32'd2);
      check_output($sformatf("fair%0d_ts", k), 32'(ev_ts), exp_ts((k <= 2) ? 0 : k - 2));
      check_output($sformatf("fair%0d_drop", k), 32'(drop_count), 32'(k));
    end
    spike_in = 8'h00;

    // Back-pressure: fill, re-pend without loss, then lose a full row of re-spikes.
    ev_ready = 1'b0;
    do_reset();
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1);
    apply_stimulus(1'b1, 8'h00, 1'b0, 8);
    check_output("bp_full_level", 32'(fifo_level), 32'd8);
    check_output("bp_full_head", 32'(ev_addr), 32'd0);
    apply_stimulus(1'b1, 8'h00, 1'b0, 11);
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1);
    check_output("bp_repend_drop", 32'(drop_count), 32'd0);
    check_output("bp_repend_level", 32'(fifo_level), 32'd8);
    apply_stimulus(1'b1, 8'h00, 1'b0, 9);
    apply_stimulus(1'b1, 8'hFF, 1'b0, 1);
    check_output("bp_drop8", 32'(drop_count), 32'd8);
    check_output("bp_hold_head", 32'(ev_addr), 32'd0);
    spike_in = 8'h00;
    ev_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      if (ev_valid) begin
        check_output($sformatf("bp_beat%0d_addr", beats), 32'(ev_addr), 32'(beats % 8));
        check_output($sformatf("bp_beat%0d_ts", beats), 32'(ev_ts), exp_ts((beats < 8) ? 0 : 20));
        beats++;
      end
      tick(1);
    end
    check_output("bp_beat_count", 32'(beats), 32'd16);
    check_output("bp_empty_after", 32'(ev_valid), 32'd0);
    check_output("bp_drop_final", 32'(drop_count), 32'd8);

    // Reset mid-operation with 5 buffered, 2 pending and one drop recorded.
    ev_ready = 1'b0;
    do_reset();
    apply_stimulus(1'b1, 8'h7F, 1'b0, 1);
    apply_stimulus(1'b1, 8'h40, 1'b0, 1);
    apply_stimulus(1'b1, 8'h00, 1'b0, 4);
    check_output("mid_level5", 32'(fifo_level), 32'd5);
    check_output("mid_drop1", 32'(drop_count), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1);
    rst_n = 1'b1;
    check_output("mid_rst_valid", 32'(ev_valid), 32'd0);
    check_output("mid_rst_level", 32'(fifo_level), 32'd0);
    check_output("mid_rst_drop", 32'(drop_count), 32'd0);
    ev_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      if (ev_valid) beats++;
      tick(1);
    end
    check_output("mid_no_stale", 32'(beats), 32'd0);

    // Small instance: drop counter saturation at 15 and timestamp wrap.
    s_ready = 1'b1;
    s_rst_n = 1'b0;
    tick(1);
    s_rst_n = 1'b1;
    s_spike = 8'h06;
    tick(1);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 14) check_output("sat_drop14", 32'(s_drop), 32'd14);
      if (k == 15) check_output("sat_drop15", 32'(s_drop), 32'd15);
      if (k == 16) check_output("sat_hold16", 32'(s_drop), 32'd15);
      if (k == 20) check_output("sat_hold20", 32'(s_drop), 32'd15);
    end
    s_spike = 8'h00;
    s_rst_n = 1'b0;
    tick(1);
    s_rst_n = 1'b1;
    tick(16);
    s_spike = 8'h04;
    tick(1);
    s_spike = 8'h00;
    tick(1);
    check_output("wrap_valid", 32'(s_valid), 32'd1);
    check_output("wrap_addr", 32'(s_addr), 32'd2);
    check_output("wrap_ts", 32'(s_ts), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Collects the one-cycle `spike` pulses from an array of `lif_neuron` instances and serialises them into address-event (AER) words. Each word carries the firing neuron's index and the cycle at which the spike was sampled. Words are buffered in a FIFO and handed to the downstream consumer over a valid/ready handshake. The block sits directly downstream of the neuron array; its `spike_in` bus is the concatenation of the neurons' `spike` outputs.

## Interface
- `N_NEURONS`, 8, number of spike inputs (≥2)
- `ADDR_W`, 3, event address width (≥ clog2(N_NEURONS))
- `TS_WIDTH`, 16, timestamp width
- `FIFO_DEPTH`, 8, event buffer entries (power of two, ≥2)
- `DROP_W`, 8, drop counter width
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `spike_in`  in  N_NEURONS  bit i = spike pulse from neuron i
- `ev_valid`  out  1  FIFO head holds an event
- `ev_ready`  in  1  consumer accepts head this cycle
- `ev_addr`  out  ADDR_W  neuron index of head event
- `ev_ts`  out  TS_WIDTH  timestamp of head event
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  entries currently stored
- `drop_count`  out  DROP_W  saturating count of lost spikes

## Operation
- Timestamp counter `ts`:
  - Increments every cycle and wraps modulo 2^TS_WIDTH.
  - It is 0 in the first cycle with `rst_n` high.
- Capture: per neuron there is a `pending[i]` flag and a `pend_ts[i]` register.
  - If `spike_in[i]`=1 and `pending[i]`=0: set `pending[i]`, latch `pend_ts[i]` = current `ts`.
  - If `spike_in[i]`=1, `pending[i]`=1, and i is not granted this cycle: the spike is dropped and `drop_count` is incremented. `drop_count` saturates at 2^DROP_W−1.
  - If `spike_in[i]`=1 and i is granted this cycle: the old event leaves, the new one is re-pended with the current `ts`, and no drop is counted.
- Multiple drops in the same cycle add their total count, saturating.
- Arbiter (round-robin):
  - A grant is issued only when some `pending` bit is set and the FIFO is not full. Fullness is judged from the start-of-cycle level, so a pop in the same cycle does not free a slot for a push.
  - The grant goes to the lowest pending index ≥ `rr_ptr`, wrapping to 0.
  - On a grant, `rr_ptr` ← (grant+1) mod N_NEURONS, `pending[grant]` is cleared, and {grant, `pend_ts[grant]`} is pushed.
  - At most one grant per cycle.
- FIFO:
  - Pop when `ev_valid && ev_ready`. Push and pop may occur in the same cycle.
  - `ev_valid` = `fifo_level`≠0.
  - `ev_addr`/`ev_ts` show the head and hold stable while `ev_valid && !ev_ready`.
- Back-pressure: while the FIFO is full, `pending` bits persist. Loss occurs only through the re-spike drop rule.

## Timing
- Reset (`rst_n`=0 at an edge) sets the following to 0: `pending`, `pend_ts`, `rr_ptr`, `ts`, FIFO pointers, `fifo_level`, `drop_count`, and `ev_valid`.
- Reset mid-operation discards all pending and buffered events.
- `ev_addr`/`ev_ts` are don't-care while `ev_valid`=0.
- Latency with an empty FIFO and no contention:
  - Spike sampled in cycle 0 → pended at the end of cycle 0 → granted and pushed at the end of cycle 1 → `ev_valid`=1 in cycle 2.
  - `ev_ts` equals the `ts` value of cycle 0.
- Throughput: one event per cycle sustained, in and out.
- `fifo_level` and `drop_count` are registered and reflect updates from the previous edge.

## Configuration
- `AER_TIMESTAMP_EN` defined: behaviour as above.
- `AER_TIMESTAMP_EN` undefined:
  - No `ts` counter and no `pend_ts` registers; FIFO entries hold only the address.
  - `ev_ts` is tied to 0. All ports are retained.
  - All other behaviour and latency are unchanged.

## Test plan
- Single spike: neuron 3 pulses in the cycle where `ts`=10, `ev_ready`=1 → two cycles later exactly one beat with `ev_addr`=3, `ev_ts`=10; `drop_count`=0.
- Simultaneous burst: neurons 0, 5, 7 pulse in one cycle, `ev_ready`=1 → events 0, 5, 7 on consecutive cycles, all with the same `ev_ts`; `rr_ptr` ends at 0.
- Fairness/drop: hold `spike_in[1]` and `spike_in[2]` high continuously, `ev_ready`=1 → grants alternate 1, 2, 1, 2, …; `drop_count` increases by 1 per cycle after the first grant.
- Back-pressure, with `ev_ready`=0:
  - All 8 neurons pulse at cycle 0 → `fifo_level`=8 after 8 grants.
  - All 8 pulse again at cycle 20 → they stay pending, no drops.
  - All 8 pulse at cycle 30 → `drop_count`=8.
  - Then `ev_ready`=1 → 16 events drain in order 0..7, 0..7.
- Saturation/wrap, with `DROP_W`=4 and `TS_WIDTH`=4:
  - 20 drops → `drop_count` holds 15.
  - Spike in the 17th cycle after reset release (`ts` wraps) → `ev_ts`=0.
- Reset mid-operation: 5 events buffered plus 2 pending, `rst_n` low for one edge → next cycle `ev_valid`=0, `fifo_level`=0, `drop_count`=0; no stale events emerge afterwards.
